// File: rtl/reg_pipe_vr.sv
`default_nettype none
// ============================================================================
// Module      : reg_pipe_vr
// Description : Valid/ready register pipeline of STAGES stages with bubble
//               collapsing, synchronous flush and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_pipe_vr #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    STAGES     = 2,
  parameter logic [DATA_WIDTH-1:0] RST_VALUE  = '0
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_flush,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [DATA_WIDTH-1:0]         i_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic [$clog2(STAGES+1)-1:0]   o_cnt
);

  localparam int CNT_W = $clog2(STAGES + 1);

  if (STAGES < 1 || STAGES > 16) begin : g_bad_stages
    $fatal(1, "reg_pipe_vr: STAGES must be in 1..16");
  end

  if (DATA_WIDTH < 1 || DATA_WIDTH > 1024) begin : g_bad_width
    $fatal(1, "reg_pipe_vr: DATA_WIDTH must be in 1..1024");
  end

  logic [STAGES-1:0]     v;
  logic [STAGES-1:0]     can_load;
  logic [STAGES-1:0]     drain;
  logic [STAGES-1:0]     in_v;
  logic [DATA_WIDTH-1:0] d    [STAGES];
  logic [DATA_WIDTH-1:0] in_d [STAGES];
  logic                  accept;

  // Ready ripples from the output stage back to stage 0 (i_ready -> o_ready).
  always_comb begin
    drain             = '0;
    can_load          = '0;
    drain[STAGES-1]   = i_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      can_load[k] = !v[k] || drain[k];
      if (k > 0) drain[k-1] = can_load[k];
    end
  end

  assign o_ready = can_load[0] && !i_flush && !i_rst;
  assign accept  = i_valid && o_ready;

  assign in_v[0] = accept;
  assign in_d[0] = i_data;

  for (genvar k = 1; k < STAGES; k++) begin : g_link
    assign in_v[k] = v[k-1];
    assign in_d[k] = d[k-1];
  end

  // Data only moves with a valid token, so bubbles never overwrite payload.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v <= '0;
      for (int k = 0; k < STAGES; k++) d[k] <= RST_VALUE;
    end else if (i_flush) begin
      v <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (can_load[k]) begin
          v[k] <= in_v[k];
          if (in_v[k]) d[k] <= in_d[k];
        end
      end
    end
  end

  assign o_valid = v[STAGES-1];
  assign o_data  = d[STAGES-1];

  always_comb begin
    o_cnt = '0;
    for (int k = 0; k < STAGES; k++) o_cnt = o_cnt + CNT_W'(v[k]);
  end

`ifndef RTL_SYN
  always_ff @(posedge i_clk) begin
    if (accept) begin
      assert (!$isunknown(i_data))
        else $fatal(1, "reg_pipe_vr: i_data has X/Z on an accepted transfer");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_pipe_vr.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_pipe_vr
// Description : Self-checking bench for reg_pipe_vr against a token-position
//               queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_pipe_vr;

  localparam int DW = 8;
  localparam int S  = 3;
  localparam int CW = $clog2(S + 1);

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_flush = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [DW-1:0] i_data = '0;
  logic          o_valid;
  logic          i_ready = 1'b1;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_cnt;

  always #5 i_clk = ~i_clk;

  reg_pipe_vr #(
    .DATA_WIDTH (DW),
    .STAGES     (S),
    .RST_VALUE  (8'h00)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_cnt   (o_cnt)
  );

  // Model: each held payload is a token with its stage position (S-1 = output).
  typedef struct {
    logic [DW-1:0] data;
    int            pos;
  } tok_t;

  tok_t          pipe_q[$];
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_data = '0;
  bit            model_ok = 1'b0;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    bit exp_rdy;
    bit exp_vld;
    bit acc;
    int prev;
    i_valid = (src_q.size() > 0);
    i_data  = i_valid ? src_q[0] : DW'($urandom);
    @(negedge i_clk);
    exp_rdy = !i_rst && !i_flush && !(pipe_q.size() == S && !i_ready);
    check("o_ready", 32'(o_ready), 32'(exp_rdy));
    if (model_ok) begin
      exp_vld = (pipe_q.size() > 0) && (pipe_q[0].pos == S - 1);
      check("o_valid", 32'(o_valid), 32'(exp_vld));
      check("o_data",  32'(o_data),  32'(exp_data));
      check("o_cnt",   32'(o_cnt),   32'(pipe_q.size()));
    end
    acc = 1'b0;
    if (i_rst) begin
      pipe_q.delete();
      exp_data = '0;
      model_ok = 1'b1;
    end else if (i_flush) begin
      pipe_q.delete();
    end else begin
      acc = i_valid && exp_rdy;
      if (pipe_q.size() > 0 && pipe_q[0].pos == S - 1 && i_ready) void'(pipe_q.pop_front());
      prev = S;
      for (int i = 0; i < pipe_q.size(); i++) begin
        pipe_q[i].pos = (pipe_q[i].pos + 1 < prev - 1) ? pipe_q[i].pos + 1 : prev - 1;
        prev = pipe_q[i].pos;
      end
      if (acc) pipe_q.push_back('{data: i_data, pos: 0});
    end
    if (pipe_q.size() > 0 && pipe_q[0].pos == S - 1) exp_data = pipe_q[0].data;
    if (acc) void'(src_q.pop_front());
    @(posedge i_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset for two cycles
    i_rst = 1'b1;
    ticks(2);
    i_rst = 1'b0;
    ticks(1);

    // Streaming
    i_ready = 1'b1;
    for (int i = 1; i <= 8; i++) src_q.push_back(DW'(i));
    ticks(14);

    // Backpressure
    i_ready = 1'b0;
    for (int i = 0; i < 5; i++) src_q.push_back(DW'(8'hA0 + i));
    ticks(6);
    i_ready = 1'b1;
    ticks(10);

    // Bubble collapse
    i_ready = 1'b0;
    src_q.push_back(8'h11);
    ticks(2);
    src_q.push_back(8'h22);
    ticks(4);
    i_ready = 1'b1;
    ticks(5);

    // Flush with full pipe
    i_ready = 1'b0;
    src_q.push_back(8'h31);
    src_q.push_back(8'h32);
    src_q.push_back(8'h33);
    ticks(5);
    i_flush = 1'b1;
    i_ready = 1'b1;
    ticks(1);
    i_flush = 1'b0;
    src_q.push_back(8'h55);
    ticks(6);

    // Reset mid-operation with two stages occupied
    i_ready = 1'b0;
    src_q.push_back(8'h61);
    src_q.push_back(8'h62);
    ticks(3);
    src_q.push_back(8'h63);
    i_rst = 1'b1;
    ticks(1);
    i_rst = 1'b0;
    src_q.delete();
    ticks(3);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      i_ready = ($urandom_range(0, 3) != 0);
      i_flush = ($urandom_range(0, 31) == 0);
      i_rst   = ($urandom_range(0, 199) == 0);
      if (src_q.size() < 4 && $urandom_range(0, 2) != 0) src_q.push_back(DW'($urandom));
      tick();
    end
    i_flush = 1'b0;
    i_rst   = 1'b0;
    i_ready = 1'b1;
    src_q.delete();
    ticks(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_pipe_vr.md
REG_PIPE_VR -- requirements
Module: reg_pipe_vr

Interface
REQ-001 Parameter DATA_WIDTH, default 32, payload width in bits; legal range 1..1024.
REQ-002 Parameter STAGES, default 2, number of pipeline register stages; legal range 1..16; out-of-range values SHALL cause an elaboration-time fatal error.
REQ-003 Parameter RST_VALUE, default '0, DATA_WIDTH-bit value loaded into every stage data register on reset.
REQ-004 i_clk  input  1  single clock; all state updates on posedge.
REQ-005 i_rst  input  1  reset, synchronous, active-high.
REQ-006 i_flush  input  1  synchronous pipeline flush, active-high.
REQ-007 i_valid  input  1  upstream payload valid.
REQ-008 o_ready  output  1  block can accept upstream payload this cycle.
REQ-009 i_data  input  DATA_WIDTH  upstream payload.
REQ-010 o_valid  output  1  downstream payload valid.
REQ-011 i_ready  input  1  downstream can accept payload this cycle.
REQ-012 o_data  output  DATA_WIDTH  downstream payload.
REQ-013 o_cnt  output  $clog2(STAGES+1)  number of occupied stages.

Function
REQ-014 Each stage k (0..STAGES-1) SHALL hold one valid bit v[k] and one data register d[k]; stage 0 faces upstream, stage STAGES-1 drives o_valid=v[STAGES-1], o_data=d[STAGES-1].
REQ-015 Upstream transfer SHALL occur in a cycle where i_valid && o_ready; downstream transfer SHALL occur in a cycle where o_valid && i_ready.
REQ-016 Stage STAGES-1 drains when i_ready; stage k<STAGES-1 drains when stage k+1 can load.
REQ-017 Stage k can load when !v[k] or stage k drains (bubble collapsing); o_ready = stage 0 can load && !i_flush.
REQ-018 The combinational path i_ready -> o_ready through the stage chain is permitted and intended; no other combinational input-to-output paths exist.
REQ-019 When stage k loads: v[k] takes the valid of stage k-1 (i_valid && o_ready for k=0); d[k] takes the upstream data only if that incoming valid is 1, otherwise d[k] holds.
REQ-020 A stage that neither loads nor drains SHALL hold v[k] and d[k].
REQ-021 Latency: payload accepted in cycle t SHALL appear with o_valid=1 in cycle t+STAGES when i_ready stays 1; sustained throughput one transfer per cycle.
REQ-022 Order SHALL be preserved; no payload is ever dropped or duplicated except by i_flush or i_rst.
REQ-023 Full (all v=1, i_ready=0): o_ready=0, all stages hold. Empty (all v=0): o_valid=0, o_data holds last value.
REQ-024 Full with i_ready=1: o_ready=1, simultaneous upstream and downstream transfers, occupancy unchanged.
REQ-025 i_flush=1: o_ready=0 that cycle; a downstream transfer in that cycle still completes; all v[k] SHALL be 0 next cycle; d[k] hold.
REQ-026 o_cnt SHALL equal the popcount of v[] every cycle.
REQ-027 When not built with RTL_SYN, an assertion SHALL fatal if i_data contains X/Z in a cycle with i_valid && o_ready.

Reset
REQ-028 i_rst=1 at posedge SHALL set all v[k]=0 and d[k]=RST_VALUE; hence o_valid=0, o_data=RST_VALUE, o_cnt=0 next cycle.
REQ-029 i_rst SHALL take priority over i_flush, i_valid and i_ready; o_ready SHALL be 0 while i_rst=1; reset mid-stream discards all held payloads.

Verification (DATA_WIDTH=8, STAGES=3, RST_VALUE=8'h00)
REQ-030 Reset: i_rst=1 for 2 cycles -> o_valid=0, o_data=8'h00, o_cnt=0, o_ready=0 during reset, 1 after.
REQ-031 Streaming: i_ready=1, push 8'h01..8'h08 back-to-back from cycle t -> 8'h01 at o_data with o_valid=1 in cycle t+3, one value per cycle in order, o_cnt=3 at steady state.
REQ-032 Backpressure: i_ready=0, push 8'hA0..8'hA4 -> only A0..A2 accepted, o_ready=0 thereafter, o_cnt=3; release i_ready -> A0,A1,A2,A3,A4 delivered in order with no gaps after the first.
REQ-033 Bubble collapse: push 8'h11, idle 1 cycle, push 8'h22, i_ready=0 -> both occupy stages 2 and 1 (o_cnt=2), o_data=8'h11.
REQ-034 Flush: 3 stages full, i_flush=1 with i_ready=1 for one cycle -> current o_data consumed, next cycle o_valid=0, o_cnt=0; subsequent push 8'h55 appears 3 cycles later.
REQ-035 Reset mid-operation: i_rst=1 while o_cnt=2 and i_valid=1 -> no accept, next cycle o_cnt=0, o_data=8'h00.
